// File: rtl/dma_io_pkg.sv
// Shared types and constants for the DMA I/O transmit path.
package dma_io_pkg;

    localparam int          WORD_W          = 32;
    localparam logic [31:0] ADDR_STRIDE_DEF = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/dma_tx_fifo.sv
// Synchronous word FIFO buffering device output ahead of the DMA bus writes.
module dma_tx_fifo
    import dma_io_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic              wr_en_s;
    logic              rd_en_s;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_en_s = push_i && !full_o;
    assign rd_en_s = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_s) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en_s) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({wr_en_s, rd_en_s})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dma_io_tx.sv
// Peripheral-side DMA transmitter: buffers device words, requests the bus and
// streams them as sequential memory writes, then hands the port back.
module dma_io_tx
    import dma_io_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          BURST_MAX   = 8,
    parameter logic [31:0] ADDR_STRIDE = ADDR_STRIDE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    output logic        full,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic        Estado_out,
    input  logic        Check_dma,
    output logic        Check_ack,
    output logic [31:0] Datos_out,
    output logic [31:0] direccion_I_O,
    output logic        MEM_WR_I_O,
    output logic        MEM_RD_I_O
);

    localparam int BW = $clog2(BURST_MAX + 1);

    state_e         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [BW-1:0]  beats_q, beats_d;
    logic           pop_s;
    logic           fifo_empty_s;
    logic [31:0]    fifo_head_s;
    logic           estado_d, ack_d, wr_d, busy_d, done_d;
    logic [31:0]    datos_d, dir_d;

    dma_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop_s),
        .data_i  (push_data),
        .data_o  (fifo_head_s),
        .full_o  (full),
        .empty_o (fifo_empty_s)
    );

    assign MEM_RD_I_O = 1'b0;

    // Next-state, address/beat bookkeeping and pop decision.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !fifo_empty_s) begin
                    addr_d  = base_addr;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (Check_dma) begin
                    beats_d = '0;
                    state_d = XFER;
                end else begin
                    state_d = REQ;
                end
            end
            XFER: begin
                // Grant loss keeps addr/beats so the burst resumes without gaps.
                if (!Check_dma) begin
                    state_d = REQ;
                end else if (fifo_empty_s) begin
                    state_d = RELEASE;
                end else begin
                    pop_s   = 1'b1;
                    addr_d  = addr_q + ADDR_STRIDE;
                    beats_d = beats_q + BW'(1);
                    if (beats_q == BW'(BURST_MAX - 1)) begin
                        state_d = RELEASE;
                    end else begin
                        state_d = XFER;
                    end
                end
            end
            RELEASE: begin
                if (!Check_dma) begin
                    state_d = fifo_empty_s ? IDLE : REQ;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        estado_d = (state_d == REQ) || (state_d == XFER);
        ack_d    = (state_d == RELEASE);
        busy_d   = (state_d != IDLE);
        done_d   = (state_q == RELEASE) && (state_d == IDLE);
        wr_d     = pop_s;
        datos_d  = pop_s ? fifo_head_s : Datos_out;
        dir_d    = pop_s ? addr_q : direccion_I_O;
    end

    // State, counters and registered bus-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= 32'd0;
            beats_q       <= '0;
            Estado_out    <= 1'b0;
            Check_ack     <= 1'b0;
            MEM_WR_I_O    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            Datos_out     <= 32'd0;
            direccion_I_O <= 32'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beats_q       <= beats_d;
            Estado_out    <= estado_d;
            Check_ack     <= ack_d;
            MEM_WR_I_O    <= wr_d;
            busy          <= busy_d;
            done          <= done_d;
            Datos_out     <= datos_d;
            direccion_I_O <= dir_d;
        end
    end

endmodule

// File: tb/tb_dma_io_tx.sv
// Directed self-checking bench for dma_io_tx with a simple DMA grant responder.
module tb_dma_io_tx;

    logic        clk = 1'b0;
    logic        rst, push, start, Check_dma;
    logic [31:0] push_data, base_addr;
    logic        full, busy, done, Estado_out, Check_ack, MEM_WR_I_O, MEM_RD_I_O;
    logic [31:0] Datos_out, direccion_I_O;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ack_rise = 0;
    logic ack_prev = 1'b0;
    logic [31:0] wr_data[$];
    logic [31:0] wr_addr[$];
    int          wr_cyc[$];

    dma_io_tx dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .full(full),
        .start(start), .base_addr(base_addr), .busy(busy), .done(done),
        .Estado_out(Estado_out), .Check_dma(Check_dma), .Check_ack(Check_ack),
        .Datos_out(Datos_out), .direccion_I_O(direccion_I_O),
        .MEM_WR_I_O(MEM_WR_I_O), .MEM_RD_I_O(MEM_RD_I_O)
    );

    always #5 clk = ~clk;

    // Bus monitor: records every write beat, done pulses and ack rises.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (MEM_WR_I_O) begin
            wr_data.push_back(Datos_out);
            wr_addr.push_back(direccion_I_O);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (Check_ack && !ack_prev) ack_rise++;
        ack_prev = Check_ack;
    end

    task automatic clear_log();
        wr_data.delete(); wr_addr.delete(); wr_cyc.delete();
    endtask

    task automatic push_word(input logic [31:0] d);
        push = 1'b1; push_data = d;
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] a);
        start = 1'b1; base_addr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    // DMA responder: grant gdelay cycles after a request, release on ack, until done.
    task automatic serve(input int gdelay, input int max_cyc);
        int d0 = done_cnt;
        int wcnt = 0;
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_cnt > d0) begin ok = 1'b1; break; end
            if (Check_ack) begin Check_dma = 1'b0; wcnt = 0; end
            else if (Estado_out && !Check_dma) begin
                if (wcnt >= gdelay) Check_dma = 1'b1; else wcnt++;
            end
        end
        Check_dma = 1'b0;
        n_total++; if (ok !== 1'b1) $display("FAIL serve_timeout got done=%0b exp 1", ok); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b0; start = 1'b0; Check_dma = 1'b0;
        push_data = 32'd0; base_addr = 32'd0;
        repeat (3) @(negedge clk);
        n_total++; if ({full, busy, done, Estado_out, Check_ack, MEM_WR_I_O, MEM_RD_I_O, Datos_out, direccion_I_O} !== 71'd0)
            $display("FAIL reset_outputs got nonzero exp all 0"); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if ({full, busy} !== 2'b00) $display("FAIL reset_release got %b exp 00", {full, busy}); else n_pass++;
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        int a0 = ack_rise;
        clear_log();
        push_word(32'hA0); push_word(32'hA1); push_word(32'hA2);
        pulse_start(32'h100);
        n_total++; if ({Estado_out, busy} !== 2'b11) $display("FAIL basic_request got %b exp 11", {Estado_out, busy}); else n_pass++;
        serve(2, 100);
        n_total++; if (wr_data.size() !== 3) $display("FAIL basic_count got %0d exp 3", wr_data.size()); else n_pass++;
        for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
            n_total++; if (wr_data[i] !== 32'hA0 + i) $display("FAIL basic_data[%0d] got %h exp %h", i, wr_data[i], 32'hA0 + i); else n_pass++;
            n_total++; if (wr_addr[i] !== 32'h100 + 4 * i) $display("FAIL basic_addr[%0d] got %h exp %h", i, wr_addr[i], 32'h100 + 4 * i); else n_pass++;
        end
        if (wr_cyc.size() == 3) begin
            n_total++; if (wr_cyc[2] - wr_cyc[0] !== 2) $display("FAIL basic_consecutive got span %0d exp 2", wr_cyc[2] - wr_cyc[0]); else n_pass++;
        end
        n_total++; if (done_cnt - d0 !== 1) $display("FAIL basic_done got %0d exp 1", done_cnt - d0); else n_pass++;
        n_total++; if (ack_rise - a0 !== 1) $display("FAIL basic_ack got %0d exp 1", ack_rise - a0); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_idle got busy=%b exp 0", busy); else n_pass++;
        n_total++; if ({Datos_out, direccion_I_O} !== {32'hA2, 32'h108}) $display("FAIL basic_hold got %h/%h exp a2/108", Datos_out, direccion_I_O); else n_pass++;
    endtask

    task automatic test_burst_split();
        int a0 = ack_rise;
        clear_log();
        for (int i = 0; i < 8; i++) push_word(32'h10 + i);
        pulse_start(32'h0);
        fork
            serve(0, 200);
            begin
                for (int i = 0; i < 50 && wr_data.size() == 0; i++) @(negedge clk);
                push_word(32'h18); push_word(32'h19);
            end
        join
        n_total++; if (wr_data.size() !== 10) $display("FAIL split_count got %0d exp 10", wr_data.size()); else n_pass++;
        for (int i = 0; i < 10 && i < wr_data.size(); i++) begin
            n_total++; if ({wr_data[i], wr_addr[i]} !== {32'h10 + i, 32'h0 + 4 * i})
                $display("FAIL split_word[%0d] got %h@%h exp %h@%h", i, wr_data[i], wr_addr[i], 32'h10 + i, 4 * i); else n_pass++;
        end
        n_total++; if (ack_rise - a0 !== 2) $display("FAIL split_bursts got %0d exp 2", ack_rise - a0); else n_pass++;
        if (wr_cyc.size() == 10) begin
            n_total++; if (wr_cyc[7] - wr_cyc[0] !== 7) $display("FAIL split_first_span got %0d exp 7", wr_cyc[7] - wr_cyc[0]); else n_pass++;
        end
    endtask

    task automatic test_grant_loss();
        clear_log();
        for (int i = 0; i < 4; i++) push_word(32'hC0 + i);
        pulse_start(32'h200);
        @(negedge clk);
        Check_dma = 1'b1;
        for (int i = 0; i < 20 && wr_data.size() < 2; i++) @(negedge clk);
        Check_dma = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (MEM_WR_I_O !== 1'b0) $display("FAIL loss_wr_low[%0d] got %b exp 0", i, MEM_WR_I_O); else n_pass++;
        end
        n_total++; if ({wr_data.size() == 2, Estado_out} !== 2'b11) $display("FAIL loss_paused got n=%0d req=%b exp 2/1", wr_data.size(), Estado_out); else n_pass++;
        serve(1, 100);
        n_total++; if (wr_data.size() !== 4) $display("FAIL loss_count got %0d exp 4", wr_data.size()); else n_pass++;
        for (int i = 0; i < 4 && i < wr_data.size(); i++) begin
            n_total++; if ({wr_data[i], wr_addr[i]} !== {32'hC0 + i, 32'h200 + 4 * i})
                $display("FAIL loss_word[%0d] got %h@%h exp %h@%h", i, wr_data[i], wr_addr[i], 32'hC0 + i, 32'h200 + 4 * i); else n_pass++;
        end
    endtask

    task automatic test_full_empty();
        int d0;
        clear_log();
        for (int i = 0; i < 9; i++) begin
            push_word(32'h30 + i);
            if (i == 6) begin
                n_total++; if (full !== 1'b0) $display("FAIL full_early got %b exp 0", full); else n_pass++;
            end
            if (i == 7) begin
                n_total++; if (full !== 1'b1) $display("FAIL full_at_8 got %b exp 1", full); else n_pass++;
            end
        end
        pulse_start(32'h40);
        serve(0, 100);
        n_total++; if (wr_data.size() !== 8) $display("FAIL full_count got %0d exp 8", wr_data.size()); else n_pass++;
        if (wr_data.size() == 8) begin
            n_total++; if ({wr_data[7], wr_addr[7]} !== {32'h37, 32'h5C}) $display("FAIL full_last got %h@%h exp 37@5c", wr_data[7], wr_addr[7]); else n_pass++;
        end
        n_total++; if (full !== 1'b0) $display("FAIL full_cleared got %b exp 0", full); else n_pass++;
        d0 = done_cnt;
        pulse_start(32'h80);
        repeat (5) @(negedge clk);
        n_total++; if ({Estado_out, busy, done_cnt - d0 == 0} !== 3'b001)
            $display("FAIL empty_start got req=%b busy=%b dones=%0d exp 0/0/0", Estado_out, busy, done_cnt - d0); else n_pass++;
    endtask

    task automatic test_concurrent_push();
        int a0 = ack_rise;
        clear_log();
        push_word(32'h50); push_word(32'h51);
        pulse_start(32'h300);
        fork
            serve(1, 200);
            begin
                for (int i = 0; i < 50 && wr_data.size() == 0; i++) @(negedge clk);
                for (int i = 0; i < 6; i++) push_word(32'h52 + i);
            end
        join
        n_total++; if (wr_data.size() !== 8) $display("FAIL conc_count got %0d exp 8", wr_data.size()); else n_pass++;
        for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
            n_total++; if ({wr_data[i], wr_addr[i]} !== {32'h50 + i, 32'h300 + 4 * i})
                $display("FAIL conc_word[%0d] got %h@%h exp %h@%h", i, wr_data[i], wr_addr[i], 32'h50 + i, 32'h300 + 4 * i); else n_pass++;
        end
        n_total++; if (ack_rise - a0 !== 1) $display("FAIL conc_single_burst got %0d exp 1", ack_rise - a0); else n_pass++;
        n_total++; if ({busy, full} !== 2'b00) $display("FAIL conc_idle got %b exp 00", {busy, full}); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        bit seen = 1'b0;
        push_word(32'hE0); push_word(32'hE1); push_word(32'hE2);
        pulse_start(32'h400);
        Check_dma = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (MEM_WR_I_O) begin seen = 1'b1; break; end
        end
        n_total++; if (seen !== 1'b1) $display("FAIL mid_write_seen got %b exp 1", seen); else n_pass++;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++; if ({busy, Estado_out, MEM_WR_I_O, Check_ack, done, Datos_out, direccion_I_O} !== 69'd0)
            $display("FAIL mid_reset got wr=%b req=%b busy=%b exp all 0", MEM_WR_I_O, Estado_out, busy); else n_pass++;
        Check_dma = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if ({full, busy, Estado_out} !== 3'b000) $display("FAIL mid_after got %b exp 000", {full, busy, Estado_out}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst_split();
        test_grant_loss();
        test_full_empty();
        test_concurrent_push();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dma_io_tx.md
Name: dma_io_tx

Overview:
- Peripheral-side transmitter for the DMA I/O path.
- Buffers words produced by an I/O device and requests the bus from the DMA controller.
- Once granted, drives sequential memory writes (data, address, MEM_WR) into the DMA's I/O mux inputs.
- Completes the check/acknowledge handshake so the DMA returns the memory port to the processor.

Parameters:
- DEPTH, 8: FIFO depth in 32-bit words (power of two, ≥2).
- BURST_MAX, 8: maximum words written per grant (1..DEPTH).
- ADDR_STRIDE, 4: address increment per word, in bytes.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- push  in  1  device writes push_data into FIFO
- push_data  in  32  word from device
- full  out  1  FIFO full; push ignored while high
- start  in  1  one-cycle pulse; latches base_addr, arms a transfer
- base_addr  in  32  destination start address
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse on return to IDLE after a transfer
- Estado_out  out  1  bus request to DMA
- Check_dma  in  1  grant from DMA (its Check_out)
- Check_ack  out  1  release acknowledge to DMA (its Check_in)
- Datos_out  out  32  word presented to DMA
- direccion_I_O  out  32  memory address for the current word
- MEM_WR_I_O  out  1  write strobe, one word per cycle when high
- MEM_RD_I_O  out  1  tied 0

Behaviour:
- Reset (async, immediate): all outputs 0, FIFO empty, state IDLE, address register 0.
- FIFO: push accepted when !full. Push and pop in the same cycle are allowed, and count stays unchanged. Pointers wrap modulo DEPTH. A push while full is dropped with no error.
- States:
  - IDLE: on start with FIFO non-empty, latch addr←base_addr and go to REQ. A start with FIFO empty is ignored; stay in IDLE, no done pulse.
  - REQ: Estado_out=1. Wait for Check_dma=1, then go to XFER; beat counter←0.
  - XFER: Estado_out=1.
    - Each cycle with Check_dma=1 and FIFO non-empty: Datos_out=FIFO head, direccion_I_O=addr, MEM_WR_I_O=1. At the clock edge, pop, addr+=ADDR_STRIDE (32-bit wrap), beats+=1.
    - When beats reaches BURST_MAX, or the FIFO goes empty, go to RELEASE.
    - If Check_dma drops in XFER: MEM_WR_I_O=0 that cycle, no pop, return to REQ. addr and beats are kept; beats resets only at a new grant. No word is lost or duplicated.
  - RELEASE: Estado_out=0, Check_ack=1. Hold until Check_dma=0.
    - If the FIFO is non-empty at that point, go to REQ (next burst continues from addr).
    - Otherwise go to IDLE and pulse done.
- Outputs are registered. First MEM_WR_I_O occurs 1 cycle after Check_dma is sampled high in REQ.
- Datos_out and direccion_I_O hold their last value when MEM_WR_I_O=0.
- start while busy: ignored.
- push during XFER is allowed. A word pushed during a burst joins the current burst if BURST_MAX is not yet reached.
- Reset mid-transfer: immediate return to reset values. Estado_out and MEM_WR_I_O drop asynchronously.

Decomposition:
- Package dma_io_pkg:
  - state typedef {IDLE, REQ, XFER, RELEASE}.
  - ADDR_STRIDE default.
  - Word width constant 32.
- Sub-module dma_tx_fifo: synchronous FIFO with push, pop, data, full, empty, async reset. The FSM, address counter and beat counter stay in dma_io_tx.

Test Plan:
- Reset check: rst=1 mid-stream → all outputs 0 within the same cycle; after release, full=0, busy=0.
- Basic transfer: push 0xA0,0xA1,0xA2; start with base_addr=0x100; grant 2 cycles after Estado_out → writes 0xA0@0x100, 0xA1@0x104, 0xA2@0x108 on consecutive cycles. Then Check_ack=1 until grant drops, then done pulse, busy=0.
- Burst split: push 10 words, BURST_MAX=8 → 8 writes at 0x0..0x1C, then release/ack, re-request, then 2 writes at 0x20, 0x24, then done.
- Grant loss: drop Check_dma after 2nd write of 4 → MEM_WR low, no pop. Regrant → 3rd word at base+8, with no duplicate and no skip.
- Full and empty edges: push 9 words with DEPTH=8 → full after the 8th, 9th dropped, only 8 written. Start with FIFO empty → no Estado_out, no done.
- Concurrent push: push one word per cycle during XFER → words join the burst up to BURST_MAX, and count stays consistent.
